// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-point iterator and its checker:
// sample width, state encoding and the map f(x) = (x + k) >> 1.
package fp_pkg;

    localparam int FP_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        REPEAT = 2'd2,
        DONE   = 2'd3
    } state_e;

    // 9-bit sum keeps the carry so the halved result always fits in FP_W bits
    function automatic logic [FP_W-1:0] fp_next(input logic [FP_W-1:0] x,
                                                 input logic [FP_W-1:0] k);
        logic [FP_W:0] sum;
        sum = {1'b0, x} + {1'b0, k};
        return sum[FP_W:1];
    endfunction

endpackage

// File: rtl/fp_step.sv
// One step of the orbit: nxt = f(x), plus a flag when x is already a fixed point.
module fp_step
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] x,
    input  logic [FP_W-1:0] k,
    output logic [FP_W-1:0] nxt,
    output logic            is_fixed
);

    always_comb begin
        nxt      = fp_next(x, k);
        is_fixed = (nxt == x);
    end

endmodule

// File: rtl/fixed_point_iterator.sv
// Streams the orbit of f(x) = (x + k) >> 1 from a seed until a fixed point or MAX_ITER values.
// Optional macro FP_ITER_REPEAT_EN: re-emit the fixed value once so a pairwise checker sees x*, x*.
module fixed_point_iterator
    import fp_pkg::*;
#(
    parameter int MAX_ITER = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic [7:0] k,
    output logic [7:0] x_out,
    output logic       x_valid,
    input  logic       x_ready,
    output logic       busy,
    output logic       done,
    output logic       fixed,
    output logic [7:0] iter_count
);

    state_e          state_q, state_d;
    logic [FP_W-1:0] x_q, x_d;
    logic [FP_W-1:0] k_q, k_d;
    logic [7:0]      iter_q, iter_d;
    logic            fixed_q, fixed_d;

    logic [FP_W-1:0] nxt;
    logic            is_fixed;
    logic            xfer;
    logic            last;

    fp_step u_step (
        .x        (x_q),
        .k        (k_q),
        .nxt      (nxt),
        .is_fixed (is_fixed)
    );

    assign xfer = x_valid & x_ready;
    assign last = (({1'b0, iter_q} + 9'd1) == 9'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            k_q     <= '0;
            iter_q  <= '0;
            fixed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            fixed_q <= fixed_d;
        end
    end

    // Fixed-point detection wins over the iteration limit on the same transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = EMIT;
            EMIT: begin
                if (xfer) begin
                    if (is_fixed) begin
`ifdef FP_ITER_REPEAT_EN
                        state_d = REPEAT;
`else
                        state_d = DONE;
`endif
                    end else if (last) begin
                        state_d = DONE;
                    end
                end
            end
            REPEAT: if (xfer) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        k_d     = k_q;
        iter_d  = iter_q;
        fixed_d = fixed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = seed;
                    k_d     = k;
                    iter_d  = '0;
                    fixed_d = 1'b0;
                end
            end
            EMIT: begin
                if (xfer) begin
                    iter_d = iter_q + 8'd1;
                    if (is_fixed) begin
`ifndef FP_ITER_REPEAT_EN
                        fixed_d = 1'b1;
`endif
                    end else if (!last) begin
                        x_d = nxt;
                    end
                end
            end
            REPEAT: begin
                if (xfer) begin
                    iter_d  = iter_q + 8'd1;
                    fixed_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        x_out      = x_q;
        x_valid    = (state_q == EMIT) || (state_q == REPEAT);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        fixed      = fixed_q;
        iter_count = iter_q;
    end

endmodule
